// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller: state encoding,
// serve-direction constants and default grid geometry.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE      = 3'd1,
        S_RUNNING    = 3'd2,
        S_POINT      = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam int DEF_GAME_WIDTH    = 40;
    localparam int DEF_GAME_HEIGHT   = 30;
    localparam int DEF_PADDLE_HEIGHT = 6;

endpackage

// File: rtl/pong_frame_timer.sv
// 8-bit loadable down-counter stepped by the frame tick; o_Done fires on a
// tick that arrives while the count is already zero.
module pong_frame_timer (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Tick,
    input  logic       i_Load,
    input  logic [7:0] i_Load_Val,
    output logic       o_Done
);

    logic [7:0] r_count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_count <= 8'd0;
        end else if (i_Load) begin
            r_count <= i_Load_Val;
        end else if (i_Tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_Done = i_Tick && (r_count == 8'd0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: start-edge detection, timed serve, pause, miss
// scoring and a timed match-over hold that clears the scores.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int GAME_WIDTH      = DEF_GAME_WIDTH,
    parameter int GAME_HEIGHT     = DEF_GAME_HEIGHT,
    parameter int COORD_W         = 6,
    parameter int PADDLE_HEIGHT   = DEF_PADDLE_HEIGHT,
    parameter int SCORE_LIMIT     = 9,
    parameter int SCORE_W         = 4,
    parameter int SERVE_FRAMES    = 60,
    parameter int WIN_HOLD_FRAMES = 180
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Frame_Tick,
    input  logic               i_Game_Start,
    input  logic               i_Pause,
    input  logic [COORD_W-1:0] i_Ball_X,
    input  logic [COORD_W-1:0] i_Ball_Y,
    input  logic [COORD_W-1:0] i_Paddle_Y_P1,
    input  logic [COORD_W-1:0] i_Paddle_Y_P2,
    output logic               o_Game_Active,
    output logic               o_Ball_Reset,
    output logic               o_Serve_Dir,
    output logic [SCORE_W-1:0] o_P1_Score,
    output logic [SCORE_W-1:0] o_P2_Score,
    output logic               o_Point_Pulse,
    output logic               o_Match_Over,
    output logic               o_Winner,
    output logic [2:0]         o_State
);

    localparam logic [COORD_W-1:0] RIGHT_COL = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W:0]   PH_M1     = (COORD_W + 1)'(PADDLE_HEIGHT - 1);
    localparam logic [COORD_W:0]   ROW_MAX   = (COORD_W + 1)'(GAME_HEIGHT - 1);

    state_t r_state, w_next_state;

    logic r_start_prev, r_armed, w_start_rise;
    logic r_game_active, r_ball_reset, r_serve_dir, r_point_pulse;
    logic r_match_over, r_winner, r_scorer_p2;
    logic [SCORE_W-1:0] r_p1_score, r_p2_score;

    logic w_game_active_next, w_ball_reset_next, w_serve_dir_next, w_point_pulse_next;
    logic w_match_over_next, w_winner_next, w_scorer_p2_next;
    logic [SCORE_W-1:0] w_p1_score_next, w_p2_score_next, w_p1_inc, w_p2_inc;

    logic               w_limit_hit, w_p1_miss, w_p2_miss, w_miss;
    logic               w_timer_load, w_timer_done;
    logic [7:0]         w_timer_val;
    logic [1:0]         w_hit;
    logic [COORD_W-1:0] w_pad_y [2];
    logic [COORD_W:0]   w_ball_y;

    // r_armed masks the first cycle after reset so a start held through reset is not an edge
    assign w_start_rise = i_Game_Start && !r_start_prev && r_armed;

    assign w_pad_y[0] = i_Paddle_Y_P1;
    assign w_pad_y[1] = i_Paddle_Y_P2;
    assign w_ball_y   = {1'b0, i_Ball_Y};

    // Windows are widened by one bit so a paddle near the bottom cannot wrap
    for (genvar gi = 0; gi < 2; gi++) begin : g_window
        logic [COORD_W:0] w_top, w_bot_raw, w_bot;
        assign w_top     = {1'b0, w_pad_y[gi]};
        assign w_bot_raw = w_top + PH_M1;
        assign w_bot     = (w_bot_raw > ROW_MAX) ? ROW_MAX : w_bot_raw;
        assign w_hit[gi] = (w_ball_y >= w_top) && (w_ball_y <= w_bot);
    end

    assign w_p1_miss = (r_state == S_RUNNING) && !i_Pause && (i_Ball_X == '0) && !w_hit[0];
    assign w_p2_miss = (r_state == S_RUNNING) && !i_Pause && (i_Ball_X == RIGHT_COL) && !w_hit[1];
    assign w_miss    = w_p1_miss || w_p2_miss;

    assign w_p1_inc    = r_p1_score + SCORE_W'(1);
    assign w_p2_inc    = r_p2_score + SCORE_W'(1);
    assign w_limit_hit = (r_scorer_p2 ? w_p2_inc : w_p1_inc) == SCORE_W'(SCORE_LIMIT);

    assign w_timer_load = ((r_state == S_IDLE) && w_start_rise) || (r_state == S_POINT);
    assign w_timer_val  = ((r_state == S_POINT) && w_limit_hit) ? 8'(WIN_HOLD_FRAMES) : 8'(SERVE_FRAMES);

    pong_frame_timer u_timer (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Tick     (i_Frame_Tick),
        .i_Load     (w_timer_load),
        .i_Load_Val (w_timer_val),
        .o_Done     (w_timer_done)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (w_start_rise) w_next_state = S_SERVE;
            S_SERVE:      if (w_timer_done) w_next_state = S_RUNNING;
            S_RUNNING:    if (w_miss)       w_next_state = S_POINT;
            S_POINT:      w_next_state = w_limit_hit ? S_MATCH_OVER : S_SERVE;
            S_MATCH_OVER: if (w_timer_done) w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_game_active_next = (r_state == S_RUNNING) && !i_Pause && !w_miss;
        w_ball_reset_next  = (w_next_state != S_RUNNING);
        w_match_over_next  = (w_next_state == S_MATCH_OVER);
        w_point_pulse_next = (r_state == S_POINT);
        w_serve_dir_next   = r_serve_dir;
        w_winner_next      = r_winner;
        w_scorer_p2_next   = r_scorer_p2;
        w_p1_score_next    = r_p1_score;
        w_p2_score_next    = r_p2_score;
        case (r_state)
            S_RUNNING: if (w_miss) w_scorer_p2_next = w_p1_miss;
            S_POINT: begin
                if (r_scorer_p2) w_p2_score_next = w_p2_inc;
                else             w_p1_score_next = w_p1_inc;
                if (w_limit_hit) w_winner_next = r_scorer_p2;
                else             w_serve_dir_next = r_scorer_p2 ? SERVE_LEFT : SERVE_RIGHT;
            end
            S_MATCH_OVER: if (w_timer_done) begin
                w_p1_score_next  = '0;
                w_p2_score_next  = '0;
                w_serve_dir_next = SERVE_LEFT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_start_prev  <= 1'b0;
            r_armed       <= 1'b0;
            r_game_active <= 1'b0;
            r_ball_reset  <= 1'b1;
            r_serve_dir   <= SERVE_LEFT;
            r_point_pulse <= 1'b0;
            r_match_over  <= 1'b0;
            r_winner      <= 1'b0;
            r_scorer_p2   <= 1'b0;
            r_p1_score    <= '0;
            r_p2_score    <= '0;
        end else begin
            r_start_prev  <= i_Game_Start;
            r_armed       <= 1'b1;
            r_game_active <= w_game_active_next;
            r_ball_reset  <= w_ball_reset_next;
            r_serve_dir   <= w_serve_dir_next;
            r_point_pulse <= w_point_pulse_next;
            r_match_over  <= w_match_over_next;
            r_winner      <= w_winner_next;
            r_scorer_p2   <= w_scorer_p2_next;
            r_p1_score    <= w_p1_score_next;
            r_p2_score    <= w_p2_score_next;
        end
    end

    assign o_Game_Active = r_game_active;
    assign o_Ball_Reset  = r_ball_reset;
    assign o_Serve_Dir   = r_serve_dir;
    assign o_P1_Score    = r_p1_score;
    assign o_P2_Score    = r_p2_score;
    assign o_Point_Pulse = r_point_pulse;
    assign o_Match_Over  = r_match_over;
    assign o_Winner      = r_winner;
    assign o_State       = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with SERVE_FRAMES=2 and WIN_HOLD_FRAMES=3.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       pause = 1'b0;
    logic [5:0] ball_x = 6'd20;
    logic [5:0] ball_y = 6'd10;
    logic [5:0] p1_y = 6'd2;
    logic [5:0] p2_y = 6'd20;
    logic       game_active, ball_reset, serve_dir, point_pulse, match_over, winner;
    logic [3:0] p1_score, p2_score;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .SERVE_FRAMES    (2),
        .WIN_HOLD_FRAMES (3)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Frame_Tick  (frame_tick),
        .i_Game_Start  (game_start),
        .i_Pause       (pause),
        .i_Ball_X      (ball_x),
        .i_Ball_Y      (ball_y),
        .i_Paddle_Y_P1 (p1_y),
        .i_Paddle_Y_P2 (p2_y),
        .o_Game_Active (game_active),
        .o_Ball_Reset  (ball_reset),
        .o_Serve_Dir   (serve_dir),
        .o_P1_Score    (p1_score),
        .o_P2_Score    (p2_score),
        .o_Point_Pulse (point_pulse),
        .o_Match_Over  (match_over),
        .o_Winner      (winner),
        .o_State       (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic start_game();
        game_start = 1'b0;
        step();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic serve_to_running();
        repeat (3) frame();
        step();
    endtask

    task automatic point_p1();
        ball_x = 6'd39; ball_y = 6'd0; p2_y = 6'd20;
        step();
        ball_x = 6'd20; ball_y = 6'd10;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; game_start = 1'b1;
        repeat (2) step();
        checks++;
        if (state !== 3'd0 || ball_reset !== 1'b1 || game_active !== 1'b0 || serve_dir !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d ball_reset=%b active=%b dir=%b, expected 0/1/0/0", state, ball_reset, game_active, serve_dir);
        end
        checks++;
        if (p1_score !== 4'd0 || p2_score !== 4'd0 || point_pulse !== 1'b0 || match_over !== 1'b0 || winner !== 1'b0) begin
            errors++;
            $display("FAIL reset_score: p1=%0d p2=%0d pulse=%b over=%b win=%b, expected all 0", p1_score, p2_score, point_pulse, match_over, winner);
        end
        #3 rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL held_start_idle: state=%0d expected 0", state);
        end
        game_start = 1'b0;
        step();
        game_start = 1'b1;
        step();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL start_edge: state=%0d expected 1", state);
        end
        game_start = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_serve();
        repeat (3) step();
        frame();
        frame();
        checks++;
        if (state !== 3'd1 || ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL serve_wait: state=%0d ball_reset=%b expected 1/1", state, ball_reset);
        end
        frame();
        checks++;
        if (state !== 3'd2 || ball_reset !== 1'b0 || game_active !== 1'b0) begin
            errors++;
            $display("FAIL serve_release: state=%0d ball_reset=%b active=%b expected 2/0/0", state, ball_reset, game_active);
        end
        step();
        checks++;
        if (game_active !== 1'b1) begin
            errors++;
            $display("FAIL active_latency: active=%b expected 1", game_active);
        end
        $display("test_serve done");
    endtask

    task automatic test_miss();
        ball_x = 6'd0; ball_y = 6'd7; p1_y = 6'd2;
        step();
        checks++;
        if (state !== 3'd2 || p2_score !== 4'd0) begin
            errors++;
            $display("FAIL edge_hit: state=%0d p2=%0d expected 2/0", state, p2_score);
        end
        ball_y = 6'd10;
        step();
        checks++;
        if (state !== 3'd3 || game_active !== 1'b0 || p2_score !== 4'd0) begin
            errors++;
            $display("FAIL miss_point: state=%0d active=%b p2=%0d expected 3/0/0", state, game_active, p2_score);
        end
        ball_x = 6'd20;
        step();
        checks++;
        if (state !== 3'd1 || p2_score !== 4'd1 || point_pulse !== 1'b1 || serve_dir !== 1'b0 || ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL p2_scored: state=%0d p2=%0d pulse=%b dir=%b rst=%b expected 1/1/1/0/1", state, p2_score, point_pulse, serve_dir, ball_reset);
        end
        step();
        checks++;
        if (point_pulse !== 1'b0 || p1_score !== 4'd0) begin
            errors++;
            $display("FAIL pulse_width: pulse=%b p1=%0d expected 0/0", point_pulse, p1_score);
        end
        serve_to_running();
        $display("test_miss done");
    endtask

    task automatic test_pause();
        pause = 1'b1;
        step();
        checks++;
        if (game_active !== 1'b0 || state !== 3'd2) begin
            errors++;
            $display("FAIL pause_active: active=%b state=%0d expected 0/2", game_active, state);
        end
        ball_x = 6'd0; ball_y = 6'd10; p1_y = 6'd2;
        repeat (3) step();
        checks++;
        if (state !== 3'd2 || p2_score !== 4'd1) begin
            errors++;
            $display("FAIL pause_no_point: state=%0d p2=%0d expected 2/1", state, p2_score);
        end
        pause = 1'b0;
        step();
        ball_x = 6'd20;
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL unpause_miss: state=%0d expected 3", state);
        end
        step();
        checks++;
        if (p2_score !== 4'd2 || state !== 3'd1) begin
            errors++;
            $display("FAIL unpause_score: p2=%0d state=%0d expected 2/1", p2_score, state);
        end
        serve_to_running();
        $display("test_pause done");
    endtask

    task automatic test_match();
        for (int i = 1; i <= 8; i++) begin
            point_p1();
            checks++;
            if (p1_score !== 4'(i) || serve_dir !== 1'b1 || state !== 3'd1) begin
                errors++;
                $display("FAIL p1_point_%0d: p1=%0d dir=%b state=%0d expected %0d/1/1", i, p1_score, serve_dir, state, i);
            end
            serve_to_running();
        end
        point_p1();
        checks++;
        if (state !== 3'd4 || p1_score !== 4'd9 || match_over !== 1'b1 || winner !== 1'b0 || p2_score !== 4'd2) begin
            errors++;
            $display("FAIL match_over: state=%0d p1=%0d p2=%0d over=%b win=%b expected 4/9/2/1/0", state, p1_score, p2_score, match_over, winner);
        end
        game_start = 1'b0; step();
        game_start = 1'b1; step();
        game_start = 1'b0; step();
        repeat (3) frame();
        checks++;
        if (state !== 3'd4 || p1_score !== 4'd9 || ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL match_hold: state=%0d p1=%0d rst=%b expected 4/9/1", state, p1_score, ball_reset);
        end
        frame();
        checks++;
        if (state !== 3'd0 || p1_score !== 4'd0 || p2_score !== 4'd0 || match_over !== 1'b0 || serve_dir !== 1'b0) begin
            errors++;
            $display("FAIL match_clear: state=%0d p1=%0d p2=%0d over=%b dir=%b expected 0/0/0/0/0", state, p1_score, p2_score, match_over, serve_dir);
        end
        $display("test_match done");
    endtask

    task automatic test_async_reset();
        start_game();
        serve_to_running();
        for (int i = 1; i <= 9; i++) begin
            point_p1();
            if (i < 9) serve_to_running();
        end
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL async_setup: state=%0d expected 4", state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || p1_score !== 4'd0 || match_over !== 1'b0 || ball_reset !== 1'b1 || winner !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d p1=%0d over=%b rst=%b win=%b expected 0/0/0/1/0", state, p1_score, match_over, ball_reset, winner);
        end
        step();
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (state !== 3'd0 || ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: state=%0d rst=%b expected 0/1", state, ball_reset);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_serve();
        test_miss();
        test_pause();
        test_match();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
